// File: rtl/gba_irq_pkg.sv
// Shared definitions for the GBA interrupt controller: source bit indices,
// the 16-bit register vector type and a helper that builds the implemented-bit mask.
package gba_irq_pkg;

  localparam int IRQ_VBLANK  = 0;
  localparam int IRQ_HBLANK  = 1;
  localparam int IRQ_VCOUNT  = 2;
  localparam int IRQ_TIMER0  = 3;
  localparam int IRQ_TIMER1  = 4;
  localparam int IRQ_TIMER2  = 5;
  localparam int IRQ_TIMER3  = 6;
  localparam int IRQ_SERIAL  = 7;
  localparam int IRQ_DMA0    = 8;
  localparam int IRQ_DMA1    = 9;
  localparam int IRQ_DMA2    = 10;
  localparam int IRQ_DMA3    = 11;
  localparam int IRQ_KEYPAD  = 12;
  localparam int IRQ_GAMEPAK = 13;

  localparam int NUM_IRQ = 14;

  typedef logic [15:0] irq_vec_t;

  // Ones in the low n bits; register bits above the implemented sources read as 0.
  function automatic irq_vec_t src_mask(input int n);
    irq_vec_t m;
    m = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/gba_irq_controller_if.sv
// CPU-register and interrupt-request bundle between the bus/peripheral side
// and the interrupt controller.
interface gba_irq_controller_if #(parameter int NUM_SRC = 14);

  logic [NUM_SRC-1:0] irq_src;
  logic               ie_wr;
  logic [15:0]        ie_wdata;
  logic               if_ack_wr;
  logic [15:0]        if_ack_data;
  logic               ime_wr;
  logic               ime_wdata;
  logic [15:0]        reg_IE;
  logic [15:0]        reg_IF;
  logic               reg_IME;
  logic               irq;
  logic               wake;

  modport master (
    output irq_src, ie_wr, ie_wdata, if_ack_wr, if_ack_data, ime_wr, ime_wdata,
    input  reg_IE, reg_IF, reg_IME, irq, wake
  );

  modport slave (
    input  irq_src, ie_wr, ie_wdata, if_ack_wr, if_ack_data, ime_wr, ime_wdata,
    output reg_IE, reg_IF, reg_IME, irq, wake
  );

endinterface

// File: rtl/irq_edge_detect.sv
// Rising-edge detector for interrupt request levels; the history register clears
// on reset so a level already high at release yields one edge.
module irq_edge_detect #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] src,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] src_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
    end else begin
      src_q <= src;
    end
  end

  assign rise = src & ~src_q;

endmodule

// File: rtl/gba_irq_controller.sv
// GBA interrupt controller: latches source edges into IF, masks with IE/IME and
// drives a registered IRQ line plus a combinational HALT wake indication.
module gba_irq_controller
  import gba_irq_pkg::*;
#(
  parameter int NUM_SRC = NUM_IRQ
) (
  input  logic                  clock_16,
  input  logic                  reset,
  gba_irq_controller_if.slave   bus
);

  localparam irq_vec_t SRC_MASK = src_mask(NUM_SRC);

  logic [NUM_SRC-1:0] rise;
  irq_vec_t           rise_ext;
  irq_vec_t           ack_mask;
  irq_vec_t           if_next;
  irq_vec_t           ie_q;
  irq_vec_t           if_q;
  logic               ime_q;
  logic               irq_q;
  logic               pending;

  irq_edge_detect #(
    .WIDTH (NUM_SRC)
  ) u_edge (
    .clk   (clock_16),
    .rst_n (reset),
    .src   (bus.irq_src),
    .rise  (rise)
  );

  // Set wins over acknowledge so an edge arriving with an ack is never dropped.
  always_comb begin
    rise_ext                = '0;
    rise_ext[NUM_SRC-1:0]   = rise;
    ack_mask                = bus.if_ack_wr ? bus.if_ack_data : '0;
    if_next                 = (if_q & ~ack_mask) | rise_ext;
  end

  assign pending = |(ie_q & if_q);

  // Register stage: IE/IF/IME state and the IRQ line derived from current state.
  always_ff @(posedge clock_16 or negedge reset) begin
    if (!reset) begin
      ie_q  <= '0;
      if_q  <= '0;
      ime_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if_q <= if_next;
      if (bus.ie_wr)  ie_q  <= bus.ie_wdata & SRC_MASK;
      if (bus.ime_wr) ime_q <= bus.ime_wdata;
      irq_q <= ime_q & pending;
    end
  end

  assign bus.reg_IE  = ie_q;
  assign bus.reg_IF  = if_q;
  assign bus.reg_IME = ime_q;
  assign bus.irq     = irq_q;
  assign bus.wake    = pending;

endmodule
